// File: rtl/riscv_wb_pkg.sv
// Shared encodings for the writeback stage: result source, load size and FSM state.
package riscv_wb_pkg;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10,
    WB_CSR  = 2'b11
  } wb_sel_e;

  typedef enum logic [1:0] {
    LS_BYTE = 2'b00,
    LS_HALF = 2'b01,
    LS_WORD = 2'b10,
    LS_RSVD = 2'b11
  } load_size_e;

  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_WAIT_LOAD = 1'b1
  } wb_state_e;
endpackage

// File: rtl/writeback_unit_if.sv
// Memory-stage to writeback handshake plus the register-file write port.
interface writeback_unit_if;
  import riscv_wb_pkg::*;

  logic              valid_in;
  logic              ready_out;
  logic              flush_in;
  logic [REG_AW-1:0] rd_addr_in;
  logic              wr_en_in;
  logic [1:0]        wb_sel_in;
  logic [1:0]        load_size_in;
  logic              load_unsigned_in;
  logic [1:0]        addr_lsb_in;
  logic [XLEN-1:0]   alu_result_in;
  logic [XLEN-1:0]   pc_plus_4_in;
  logic [XLEN-1:0]   csr_data_in;
  logic              mem_ack_in;
  logic [XLEN-1:0]   load_data_in;
  logic [REG_AW-1:0] rd_addr_out;
  logic              wr_en_out;
  logic [XLEN-1:0]   rd_out;
  logic              misaligned_out;

  modport slave (
    input  valid_in, flush_in, rd_addr_in, wr_en_in, wb_sel_in, load_size_in,
           load_unsigned_in, addr_lsb_in, alu_result_in, pc_plus_4_in,
           csr_data_in, mem_ack_in, load_data_in,
    output ready_out, rd_addr_out, wr_en_out, rd_out, misaligned_out
  );

  modport master (
    output valid_in, flush_in, rd_addr_in, wr_en_in, wb_sel_in, load_size_in,
           load_unsigned_in, addr_lsb_in, alu_result_in, pc_plus_4_in,
           csr_data_in, mem_ack_in, load_data_in,
    input  ready_out, rd_addr_out, wr_en_out, rd_out, misaligned_out
  );
endinterface

// File: rtl/load_align.sv
// Combinational load formatter: lane select, sign/zero extension and alignment check.
module load_align
  import riscv_wb_pkg::*;
(
  input  logic [XLEN-1:0] raw_in,
  input  logic [1:0]      size_in,
  input  logic            unsigned_in,
  input  logic [1:0]      lsb_in,
  output logic [XLEN-1:0] data_out,
  output logic            misaligned_out
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel       = raw_in[8*lsb_in +: 8];
    half_sel       = lsb_in[1] ? raw_in[31:16] : raw_in[15:0];
    data_out       = '0;
    misaligned_out = 1'b0;
    case (size_in)
      LS_BYTE: data_out = {{24{byte_sel[7] & ~unsigned_in}}, byte_sel};
      LS_HALF: begin
        data_out       = {{16{half_sel[15] & ~unsigned_in}}, half_sel};
        misaligned_out = lsb_in[0];
      end
      LS_WORD: begin
        data_out       = raw_in;
        misaligned_out = |lsb_in;
      end
      default: misaligned_out = 1'b1;
    endcase
  end
endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: selects the result, waits for load data and drives the register-file write port.
// state        | meaning
// ST_IDLE      | accepting one instruction per cycle
// ST_WAIT_LOAD | aligned load accepted, holding controls until mem_ack_in or flush_in
module writeback_unit
  import riscv_wb_pkg::*;
(
  input logic              clk_in,
  input logic              reset_in,
  writeback_unit_if.slave  wb
);
  wb_state_e         state;
  logic              ready;
  logic              accept;
  logic [XLEN-1:0]   result_sel;
  logic [REG_AW-1:0] held_rd_addr;
  logic              held_wr_en;
  logic [1:0]        held_size;
  logic              held_unsigned;
  logic [1:0]        held_lsb;
  logic [1:0]        align_size;
  logic              align_unsigned;
  logic [1:0]        align_lsb;
  logic [XLEN-1:0]   align_data;
  logic              align_misaligned;

  assign ready        = (state == ST_IDLE) && !reset_in;
  assign wb.ready_out = ready;
  assign accept       = wb.valid_in && ready && !wb.flush_in;

  // In IDLE the aligner only judges alignment of the offered load; in WAIT_LOAD it formats the data.
  assign align_size     = (state == ST_IDLE) ? wb.load_size_in     : held_size;
  assign align_unsigned = (state == ST_IDLE) ? wb.load_unsigned_in : held_unsigned;
  assign align_lsb      = (state == ST_IDLE) ? wb.addr_lsb_in      : held_lsb;

  load_align u_load_align (
    .raw_in         (wb.load_data_in),
    .size_in        (align_size),
    .unsigned_in    (align_unsigned),
    .lsb_in         (align_lsb),
    .data_out       (align_data),
    .misaligned_out (align_misaligned)
  );

  always_comb begin
    result_sel = wb.alu_result_in;
    case (wb.wb_sel_in)
      WB_PC4:  result_sel = wb.pc_plus_4_in;
      WB_CSR:  result_sel = wb.csr_data_in;
      default: result_sel = wb.alu_result_in;
    endcase
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state             <= ST_IDLE;
      wb.rd_out         <= '0;
      wb.rd_addr_out    <= '0;
      wb.wr_en_out      <= 1'b0;
      wb.misaligned_out <= 1'b0;
      held_rd_addr      <= '0;
      held_wr_en        <= 1'b0;
      held_size         <= '0;
      held_unsigned     <= 1'b0;
      held_lsb          <= '0;
    end else begin
      wb.wr_en_out      <= 1'b0;
      wb.misaligned_out <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (wb.wb_sel_in == WB_LOAD) begin
              if (align_misaligned) begin
                wb.misaligned_out <= 1'b1;
              end else begin
                state         <= ST_WAIT_LOAD;
                held_rd_addr  <= wb.rd_addr_in;
                held_wr_en    <= wb.wr_en_in;
                held_size     <= wb.load_size_in;
                held_unsigned <= wb.load_unsigned_in;
                held_lsb      <= wb.addr_lsb_in;
              end
            end else if (wb.wr_en_in && (wb.rd_addr_in != '0)) begin
              wb.wr_en_out   <= 1'b1;
              wb.rd_addr_out <= wb.rd_addr_in;
              wb.rd_out      <= result_sel;
            end
          end
        end
        ST_WAIT_LOAD: begin
          if (wb.flush_in) begin
            state <= ST_IDLE;
          end else if (wb.mem_ack_in) begin
            state <= ST_IDLE;
            if (held_wr_en && (held_rd_addr != '0)) begin
              wb.wr_en_out   <= 1'b1;
              wb.rd_addr_out <= held_rd_addr;
              wb.rd_out      <= align_data;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_writeback_unit.sv
// Directed stimulus with a scoreboard: expected writes/misaligned pulses are queued with their cycle.
module tb_writeback_unit;
  import riscv_wb_pkg::*;

  logic clk_in   = 1'b0;
  logic reset_in = 1'b1;
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    int          cyc;
  } exp_wr_t;

  exp_wr_t wr_q[$];
  int      mis_q[$];

  writeback_unit_if wb_if();

  writeback_unit dut (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .wb       (wb_if.slave)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk_in) begin
    if (wb_if.wr_en_out === 1'b1) begin
      if (wr_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got addr=%0d data=0x%08h expected no write (cycle %0d)",
                 wb_if.rd_addr_out, wb_if.rd_out, cyc);
      end else begin
        exp_wr_t e;
        e = wr_q.pop_front();
        check("write_cycle", cyc, e.cyc);
        check("write_addr", {27'd0, wb_if.rd_addr_out}, {27'd0, e.addr});
        check("write_data", wb_if.rd_out, e.data);
      end
    end
    if (wb_if.misaligned_out === 1'b1) begin
      if (mis_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_misaligned: got pulse expected none (cycle %0d)", cyc);
      end else begin
        check("misaligned_cycle", cyc, mis_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic clear_inputs();
    wb_if.valid_in         = 1'b0;
    wb_if.flush_in         = 1'b0;
    wb_if.rd_addr_in       = '0;
    wb_if.wr_en_in         = 1'b0;
    wb_if.wb_sel_in        = WB_ALU;
    wb_if.load_size_in     = LS_BYTE;
    wb_if.load_unsigned_in = 1'b0;
    wb_if.addr_lsb_in      = '0;
    wb_if.alu_result_in    = '0;
    wb_if.pc_plus_4_in     = '0;
    wb_if.csr_data_in      = '0;
    wb_if.mem_ack_in       = 1'b0;
    wb_if.load_data_in     = '0;
  endtask

  task automatic drive_op(input logic [1:0] sel, input logic [4:0] rd, input logic we,
                          input logic [1:0] size, input logic uns, input logic [1:0] lsb);
    wb_if.valid_in         = 1'b1;
    wb_if.wb_sel_in        = sel;
    wb_if.rd_addr_in       = rd;
    wb_if.wr_en_in         = we;
    wb_if.load_size_in     = size;
    wb_if.load_unsigned_in = uns;
    wb_if.addr_lsb_in      = lsb;
  endtask

  task automatic exp_write(input logic [4:0] a, input logic [31:0] d, input int c);
    exp_wr_t e;
    e.addr = a;
    e.data = d;
    e.cyc  = c;
    wr_q.push_back(e);
  endtask

  // Accept a load, wait gap cycles, then ack with data; expected value is hand-computed.
  task automatic do_load(input logic [4:0] rd, input logic [1:0] size, input logic uns,
                         input logic [1:0] lsb, input int gap, input logic [31:0] raw,
                         input logic [31:0] exp);
    drive_op(WB_LOAD, rd, 1'b1, size, uns, lsb);
    step();
    clear_inputs();
    wb_if.load_size_in = LS_RSVD;
    wb_if.addr_lsb_in  = 2'b01;
    for (int i = 0; i < gap; i++) begin
      check("ready_wait", {31'd0, wb_if.ready_out}, 32'd0);
      step();
    end
    wb_if.mem_ack_in   = 1'b1;
    wb_if.load_data_in = raw;
    exp_write(rd, exp, cyc + 1);
    step();
    clear_inputs();
    check("ready_after_load", {31'd0, wb_if.ready_out}, 32'd1);
  endtask

  task automatic do_misaligned(input logic [1:0] size, input logic [1:0] lsb);
    drive_op(WB_LOAD, 5'd6, 1'b1, size, 1'b0, lsb);
    mis_q.push_back(cyc + 1);
    step();
    clear_inputs();
    check("ready_misaligned", {31'd0, wb_if.ready_out}, 32'd1);
  endtask

  initial begin
    clear_inputs();
    step();
    step();
    check("rst_ready", {31'd0, wb_if.ready_out}, 32'd0);
    check("rst_rd_out", wb_if.rd_out, 32'd0);
    check("rst_rd_addr", {27'd0, wb_if.rd_addr_out}, 32'd0);
    check("rst_wr_en", {31'd0, wb_if.wr_en_out}, 32'd0);
    check("rst_misaligned", {31'd0, wb_if.misaligned_out}, 32'd0);
    reset_in = 1'b0;
    #1;
    check("ready_after_rst", {31'd0, wb_if.ready_out}, 32'd1);

    // ALU op, then back-to-back PC+4 and CSR
    drive_op(WB_ALU, 5'd5, 1'b1, LS_BYTE, 1'b0, 2'b00);
    wb_if.alu_result_in = 32'h0000_1234;
    exp_write(5'd5, 32'h0000_1234, cyc + 1);
    step();
    drive_op(WB_PC4, 5'd9, 1'b1, LS_BYTE, 1'b0, 2'b00);
    wb_if.pc_plus_4_in = 32'h0000_0104;
    exp_write(5'd9, 32'h0000_0104, cyc + 1);
    step();
    drive_op(WB_CSR, 5'd10, 1'b1, LS_BYTE, 1'b0, 2'b00);
    wb_if.csr_data_in = 32'hDEAD_BEEF;
    exp_write(5'd10, 32'hDEAD_BEEF, cyc + 1);
    step();
    // wr_en_in=0 and rd=x0: no write, outputs hold
    drive_op(WB_ALU, 5'd11, 1'b0, LS_BYTE, 1'b0, 2'b00);
    wb_if.alu_result_in = 32'h5555_5555;
    step();
    drive_op(WB_PC4, 5'd0, 1'b1, LS_BYTE, 1'b0, 2'b00);
    wb_if.pc_plus_4_in = 32'h0000_0104;
    step();
    clear_inputs();
    step();
    check("hold_rd_out", wb_if.rd_out, 32'hDEAD_BEEF);
    check("hold_rd_addr", {27'd0, wb_if.rd_addr_out}, 32'd10);

    // ack in IDLE is ignored
    wb_if.mem_ack_in   = 1'b1;
    wb_if.load_data_in = 32'hFFFF_FFFF;
    step();
    clear_inputs();

    // loads
    do_load(5'd3, LS_BYTE, 1'b0, 2'b11, 1, 32'h80FF_FF7F, 32'hFFFF_FF80);
    do_load(5'd4, LS_BYTE, 1'b1, 2'b11, 1, 32'h80FF_FF7F, 32'h0000_0080);
    do_load(5'd12, LS_HALF, 1'b0, 2'b10, 0, 32'h8001_1234, 32'hFFFF_8001);
    do_load(5'd13, LS_HALF, 1'b1, 2'b00, 2, 32'h0000_F00F, 32'h0000_F00F);
    do_load(5'd14, LS_WORD, 1'b0, 2'b00, 0, 32'h1234_5678, 32'h1234_5678);
    do_load(5'd15, LS_BYTE, 1'b0, 2'b01, 0, 32'h0000_2A00, 32'h0000_002A);

    // misaligned / reserved
    do_misaligned(LS_HALF, 2'b01);
    do_misaligned(LS_WORD, 2'b10);
    do_misaligned(LS_RSVD, 2'b00);

    // flush in IDLE suppresses acceptance
    drive_op(WB_ALU, 5'd8, 1'b1, LS_BYTE, 1'b0, 2'b00);
    wb_if.alu_result_in = 32'h0BAD_0BAD;
    wb_if.flush_in      = 1'b1;
    step();
    clear_inputs();
    check("ready_flush_idle", {31'd0, wb_if.ready_out}, 32'd1);

    // flush with ack in WAIT_LOAD: no write, IDLE next, then ALU to rd=7
    drive_op(WB_LOAD, 5'd16, 1'b1, LS_WORD, 1'b0, 2'b00);
    step();
    clear_inputs();
    check("ready_in_wait", {31'd0, wb_if.ready_out}, 32'd0);
    wb_if.flush_in     = 1'b1;
    wb_if.mem_ack_in   = 1'b1;
    wb_if.load_data_in = 32'hCAFE_F00D;
    step();
    clear_inputs();
    check("ready_after_flush", {31'd0, wb_if.ready_out}, 32'd1);
    drive_op(WB_ALU, 5'd7, 1'b1, LS_BYTE, 1'b0, 2'b00);
    wb_if.alu_result_in = 32'h0000_0077;
    exp_write(5'd7, 32'h0000_0077, cyc + 1);
    step();
    clear_inputs();
    step();

    // reset mid-load
    drive_op(WB_LOAD, 5'd17, 1'b1, LS_WORD, 1'b0, 2'b00);
    step();
    clear_inputs();
    reset_in = 1'b1;
    #1;
    check("midrst_ready", {31'd0, wb_if.ready_out}, 32'd0);
    check("midrst_rd_out", wb_if.rd_out, 32'd0);
    check("midrst_rd_addr", {27'd0, wb_if.rd_addr_out}, 32'd0);
    step();
    reset_in           = 1'b0;
    wb_if.mem_ack_in   = 1'b1;
    wb_if.load_data_in = 32'h1111_2222;
    step();
    clear_inputs();
    step();
    check("post_rst_rd_out", wb_if.rd_out, 32'd0);
    check("post_rst_rd_addr", {27'd0, wb_if.rd_addr_out}, 32'd0);
    check("post_rst_ready", {31'd0, wb_if.ready_out}, 32'd1);

    step();
    step();
    check("wr_queue_empty", wr_q.size(), 32'd0);
    check("mis_queue_empty", mis_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 Parameters: none; data width fixed at 32, register address width fixed at 5.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset. clk_in and reset_in are the first ports.
REQ-003 clk_in  input  1  rising-edge clock.
REQ-004 reset_in  input  1  asynchronous active-high reset.
REQ-005 valid_in  input  1  upstream (memory stage) instruction valid.
REQ-006 ready_out  output  1  block can accept an instruction this cycle.
REQ-007 flush_in  input  1  kill the instruction being offered or held.
REQ-008 rd_addr_in  input  5  destination register.
REQ-009 wr_en_in  input  1  instruction writes rd.
REQ-010 wb_sel_in  input  2  result source: 00 ALU, 01 load, 10 PC+4, 11 CSR.
REQ-011 load_size_in  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-012 load_unsigned_in  input  1  zero-extend the load (LBU/LHU).
REQ-013 addr_lsb_in  input  2  load address bits [1:0].
REQ-014 alu_result_in, pc_plus_4_in, csr_data_in  input  32 each  candidate results.
REQ-015 mem_ack_in  input  1  load_data_in is valid this cycle.
REQ-016 load_data_in  input  32  raw aligned memory word.
REQ-017 rd_addr_out  output  5  register file write address.
REQ-018 wr_en_out  output  1  register file write enable, one-cycle pulse.
REQ-019 rd_out  output  32  register file write data.
REQ-020 misaligned_out  output  1  one-cycle pulse on a misaligned or reserved load.

Function
REQ-021 An instruction is accepted when valid_in=1, ready_out=1 and flush_in=0.
REQ-022 ready_out SHALL be 1 only in state IDLE with reset_in=0.
REQ-023 FSM states are IDLE and WAIT_LOAD. IDLE goes to WAIT_LOAD on acceptance of a load (wb_sel=01) that is aligned. WAIT_LOAD goes to IDLE on mem_ack_in=1 or flush_in=1.
REQ-024 Non-load accepted in cycle N: rd_out, rd_addr_out and wr_en_out are registered and valid in cycle N+1 for exactly one cycle. Throughput is one instruction per cycle.
REQ-025 Load accepted in cycle N: the stage holds rd_addr and formatting controls. On mem_ack_in in cycle M (M>=N+1), the formatted result is presented in cycle M+1, and ready_out returns to 1 in cycle M+1.
REQ-026 mem_ack_in in IDLE SHALL be ignored.
REQ-027 Load formatting:
- Byte: select byte addr_lsb_in, bits [8*lsb+7:8*lsb].
- Half: select halfword addr_lsb_in[1].
- Word: whole word.
- Sign-extend unless load_unsigned_in=1.
REQ-028 Misalignment: a half load with lsb[0]=1, a word load with lsb!=00, or load_size=11 SHALL pulse misaligned_out in N+1. Such a load performs no write and does not enter WAIT_LOAD.
REQ-029 wr_en_out SHALL be 1 only if wr_en_in=1 and rd_addr_in!=0. x0 never produces a write pulse, so the downstream bypass never forwards to x0.
REQ-030 When wr_en_out=0, rd_out and rd_addr_out hold their previous values.
REQ-031 flush_in in IDLE suppresses acceptance. flush_in in WAIT_LOAD aborts the load: no write, IDLE next cycle.
REQ-032 flush_in and mem_ack_in in the same cycle: flush wins, no write.

Reset
REQ-033 While reset_in=1:
- state is IDLE.
- rd_out=0, rd_addr_out=0, wr_en_out=0, misaligned_out=0.
- ready_out=0.
REQ-034 Reset asserted in WAIT_LOAD abandons the load. No write pulse follows deassertion.

Structure
REQ-035 Package riscv_wb_pkg SHALL hold the wb_sel encodings, the load_size encodings and the FSM state encoding.
REQ-036 Sub-module load_align SHALL be purely combinational: raw word, size, unsigned flag and lsb in; 32-bit formatted result and misaligned flag out.

Verification
REQ-037 ALU op: rd=5, alu=0x0000_1234, wb_sel=00 accepted in cycle 0 -> cycle 1 shows wr_en_out=1, rd_addr_out=5, rd_out=0x0000_1234; cycle 2 shows wr_en_out=0.
REQ-038 Load LB: lsb=3, load_data=0x80FF_FF7F, ack 2 cycles after accept -> rd_out=0xFFFF_FF80; ready_out=0 until write cycle. With LBU the same stimulus -> 0x0000_0080.
REQ-039 Misaligned: LH with lsb=01 -> misaligned_out pulse, wr_en_out=0, ready_out stays 1. LW with lsb=10 -> same response.
REQ-040 x0: wb_sel=10, rd=0, pc_plus_4=0x104 -> wr_en_out stays 0.
REQ-041 Flush: flush_in and mem_ack_in together in WAIT_LOAD -> no write, IDLE next cycle. A following ALU op to rd=7 writes normally.
REQ-042 Reset mid-load: reset_in pulsed in WAIT_LOAD, then mem_ack_in -> no write pulse, outputs 0.
